bcd_source_sequencer: RTL and testbench
=======================================

Name: bcd_source_sequencer

Overview:
- Upstream producer for the 7-segment display path.
- Accepts an 8-bit binary value with a start/busy handshake.
- Converts it to three BCD digits with a sequential shift-add-3 (double-dabble) engine, one iteration per clock.
- Presents hundreds/tens/units registers plus a `ready` strobe that drives the display controller's `ready` input. Results are held stable between conversions.

Parameters:
- READY_HOLD, 1, number of consecutive cycles `ready` stays high after a conversion completes. Legal range 1..4.
- ITERATIONS, 8, number of shift iterations. Must equal the input width; fixed at 8 for this block.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  request a conversion; sampled only in IDLE
- bin_in  input  8  binary value; captured on the accepted start cycle
- busy  output  1  high from the cycle after start is accepted until return to IDLE
- ready  output  1  result-valid strobe to the display controller
- bcd_hundreds  output  3  hundreds digit, 0..2, upper bit always 0
- bcd_tens  output  4  tens digit, 0..9
- bcd_units  output  4  units digit, 0..9

Behaviour:
- Clock and reset: single clock domain, `clk`. `rst` is asynchronous and active-high.
- Reset values:
  - busy=0, ready=0, all digit outputs 0.
  - FSM goes to IDLE.
  - Internal 20-bit shift register (12 BCD bits + 8 binary bits) and 3-bit iteration counter cleared.
- FSM states: IDLE, SHIFT, DONE, HOLD.
- IDLE:
  - start=1 on a clock edge loads the shift register with {12'b0, bin_in}, clears the counter, and moves to SHIFT.
  - start=0: stay in IDLE.
- SHIFT, one iteration per cycle:
  - Each BCD nibble >= 5 gets +3 (nibble-local 4-bit add).
  - The whole 20-bit register is then shifted left by 1, in the same cycle.
  - Counter increments. The 8th iteration (counter==7) moves to DONE.
- DONE (1 cycle):
  - Copy BCD nibbles to the outputs.
  - bcd_hundreds = nibble[1:0] zero-extended to 3 bits.
  - Set ready=1, load the hold counter with READY_HOLD-1, go to HOLD.
- HOLD:
  - ready stays 1 while the hold counter is nonzero, decrementing each cycle.
  - When the count reaches 0, ready drops to 0 and the FSM returns to IDLE.
- busy:
  - High in SHIFT, DONE and HOLD; low only in IDLE.
  - Registered, so it rises the cycle after start is accepted.
- Latency:
  - start accepted at edge N.
  - Outputs valid and ready=1 after edge N+9.
  - IDLE re-entered after edge N+9+READY_HOLD.
- start while busy=1 is ignored; no queuing and no effect on the conversion in progress.
- start held high continuously gives back-to-back conversions: a new value is captured at the first IDLE edge.
- bin_in changes during SHIFT have no effect; the value was captured at start.
- Digit outputs:
  - Change only in DONE; held otherwise, including during a subsequent conversion.
  - Never show intermediate shift state.
- Reset mid-conversion: immediate return to IDLE. The conversion is lost, outputs are cleared to 0, and ready is never asserted for the aborted value.
- Input 0 must still run the full 8 iterations; there is no early exit.
- No overflow is possible (max 255 -> 2/5/5); no error output.

Optional Feature:
- Macro BCD_LEADING_ZERO_EN.
- Defined: adds two outputs, both 1 bit, both reset to 1, both updated only in DONE:
  - blank_hundreds = (hundreds==0)
  - blank_tens = (hundreds==0 && tens==0)
- Not defined: those ports do not exist and there is no related logic. All other behaviour is identical.

Test Plan:
- Reset, then start with bin_in=0 -> after 9 cycles ready=1 for 1 cycle, digits 0/0/0. With BCD_LEADING_ZERO_EN: blank_hundreds=1, blank_tens=1.
- bin_in=255 -> digits 2/5/5; busy high for exactly 9+READY_HOLD cycles.
- bin_in=128, then 7, then 99 with start held high -> sequential results 1/2/8, 0/0/7, 0/9/9. Digits stay stable between ready pulses.
- start pulsed with bin_in=200 during SHIFT of a 45 conversion -> only 0/4/5 is produced; no second ready.
- rst asserted at SHIFT iteration 4 of 173 -> busy=0, ready=0 and digits 0 immediately. A following start with 173 yields 1/7/3.
- READY_HOLD=3, bin_in=64 -> ready high for exactly 3 cycles with 0/6/4 stable; busy drops the same cycle ready drops.

Source files
------------

// File: rtl/bcd_source_sequencer.sv
// bcd_source_sequencer
// Upstream producer for the 7-segment display path. It takes an 8-bit binary
// value through a start/busy handshake and converts it to three BCD digits.
// The conversion uses a sequential shift-add-3 (double-dabble) engine that
// runs one iteration per clock. Results are held until the next conversion
// completes. A `ready` strobe of READY_HOLD cycles marks each new result.
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous active-high reset
//   start          conversion request, sampled only while idle
//   bin_in[7:0]    binary value, captured on the accepted start cycle
//   busy           high from the cycle after start is accepted until idle again
//   ready          result-valid strobe for the display controller
//   bcd_hundreds   hundreds digit 0..2 (upper bit always 0)
//   bcd_tens       tens digit 0..9
//   bcd_units      units digit 0..9
// Optional (macro BCD_LEADING_ZERO_EN):
//   blank_hundreds 1 when hundreds digit is 0
//   blank_tens     1 when hundreds and tens digits are both 0

module bcd_source_sequencer #(
    parameter int READY_HOLD = 1,   // 1..4
    parameter int ITERATIONS = 8    // must equal input width
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] bin_in,
    output logic       busy,
    output logic       ready,
    output logic [2:0] bcd_hundreds,
    output logic [3:0] bcd_tens,
    output logic [3:0] bcd_units
`ifdef BCD_LEADING_ZERO_EN
    ,
    output logic       blank_hundreds,
    output logic       blank_tens
`endif
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE, HOLD} state_t;

    localparam logic [2:0] LAST_ITER = 3'(ITERATIONS - 1);
    localparam logic [1:0] HOLD_INIT = 2'(READY_HOLD - 1);

    state_t      state;
    logic [19:0] sr;      // {hundreds, tens, units, binary}
    logic [2:0]  cnt;
    logic [1:0]  hold;

    // One double-dabble iteration: +3 on every BCD nibble >= 5, then shift
    // the whole register left by one.
    function automatic logic [19:0] dabble(input logic [19:0] r);
        logic [19:0] a;
        a = r;
        for (int k = 0; k < 3; k++) begin
            if (a[8+4*k +: 4] >= 4'd5)
                a[8+4*k +: 4] = a[8+4*k +: 4] + 4'd3;
        end
        return {a[18:0], 1'b0};
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            sr           <= '0;
            cnt          <= '0;
            hold         <= '0;
            busy         <= 1'b0;
            ready        <= 1'b0;
            bcd_hundreds <= '0;
            bcd_tens     <= '0;
            bcd_units    <= '0;
`ifdef BCD_LEADING_ZERO_EN
            blank_hundreds <= 1'b1;
            blank_tens     <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sr    <= {12'b0, bin_in};
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    sr  <= dabble(sr);
                    cnt <= cnt + 3'd1;
                    if (cnt == LAST_ITER)
                        state <= DONE;
                end
                DONE: begin
                    // Digits only move here, so no intermediate state escapes.
                    bcd_hundreds <= {1'b0, sr[17:16]};
                    bcd_tens     <= sr[15:12];
                    bcd_units    <= sr[11:8];
`ifdef BCD_LEADING_ZERO_EN
                    blank_hundreds <= (sr[17:16] == 2'd0);
                    blank_tens     <= (sr[17:16] == 2'd0) && (sr[15:12] == 4'd0);
`endif
                    ready <= 1'b1;
                    hold  <= HOLD_INIT;
                    state <= HOLD;
                end
                HOLD: begin
                    if (hold != 2'd0) begin
                        hold <= hold - 2'd1;
                    end else begin
                        ready <= 1'b0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_source_sequencer.sv
// Self-checking bench for bcd_source_sequencer. Two instances run side by side
// from the same stimulus, one with READY_HOLD=1 and one with READY_HOLD=3.
// Each is compared every cycle against a timeline model. The model counts
// cycles since a start was accepted and computes the digits with / and %.

module tb_bcd_source_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [7:0] bin_in = '0;

    logic       busy  [2];
    logic       ready [2];
    logic [2:0] hun   [2];
    logic [3:0] ten   [2];
    logic [3:0] uni   [2];
`ifdef BCD_LEADING_ZERO_EN
    logic       blh   [2];
    logic       blt   [2];
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    bcd_source_sequencer #(.READY_HOLD(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .bin_in(bin_in),
        .busy(busy[0]), .ready(ready[0]),
        .bcd_hundreds(hun[0]), .bcd_tens(ten[0]), .bcd_units(uni[0])
`ifdef BCD_LEADING_ZERO_EN
        , .blank_hundreds(blh[0]), .blank_tens(blt[0])
`endif
    );

    bcd_source_sequencer #(.READY_HOLD(3)) u_dut3 (
        .clk(clk), .rst(rst), .start(start), .bin_in(bin_in),
        .busy(busy[1]), .ready(ready[1]),
        .bcd_hundreds(hun[1]), .bcd_tens(ten[1]), .bcd_units(uni[1])
`ifdef BCD_LEADING_ZERO_EN
        , .blank_hundreds(blh[1]), .blank_tens(blt[1])
`endif
    );

    // Reference model: a conversion is "active" for 9+RH cycles after the
    // accepting edge. Results appear 9 cycles in.
    bit act [2];
    int age [2];
    int val [2];
    int eh  [2];
    int et  [2];
    int eu  [2];
    int pulses [2];

    function automatic int rh(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            act[i] = 0; age[i] = 0; val[i] = 0;
            eh[i] = 0; et[i] = 0; eu[i] = 0;
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            if (!act[i]) begin
                if (start) begin
                    act[i] = 1; age[i] = 0; val[i] = int'(bin_in);
                end
            end else begin
                age[i]++;
                if (age[i] == 9) begin
                    eh[i] = val[i] / 100;
                    et[i] = (val[i] / 10) % 10;
                    eu[i] = val[i] % 10;
                    pulses[i]++;
                end
                if (age[i] == 9 + rh(i)) act[i] = 0;
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("busy%0d", i),  int'(busy[i]),  int'(act[i]));
            chk($sformatf("ready%0d", i), int'(ready[i]), int'(act[i] && age[i] >= 9));
            chk($sformatf("hund%0d", i),  int'(hun[i]),   eh[i]);
            chk($sformatf("tens%0d", i),  int'(ten[i]),   et[i]);
            chk($sformatf("units%0d", i), int'(uni[i]),   eu[i]);
`ifdef BCD_LEADING_ZERO_EN
            chk($sformatf("blank_h%0d", i), int'(blh[i]), int'(eh[i] == 0));
            chk($sformatf("blank_t%0d", i), int'(blt[i]), int'(eh[i] == 0 && et[i] == 0));
`endif
        end
    endtask

    // Drive inputs on the falling edge, let one rising edge happen, check.
    task automatic cycle(input bit s, input int b);
        @(negedge clk);
        start  = s;
        bin_in = 8'(b);
        @(posedge clk);
        #1;
        model_edge();
        check_all();
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear at once.
    task automatic async_reset();
        @(negedge clk);
        start = 1'b0;
        rst   = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic idle_until_quiet();
        int guard;
        guard = 0;
        while ((act[0] || act[1]) && guard < 40) begin
            cycle(1'b0, int'($urandom_range(255)));
            guard++;
        end
        chk("drain_timeout", guard < 40 ? 1 : 0, 1);
    endtask

    initial begin
        int p0;
        int p3;

        model_reset();
        pulses[0] = 0;
        pulses[1] = 0;
        async_reset();

        // Zero still needs the full 8 iterations.
        cycle(1'b1, 0);
        for (int k = 0; k < 14; k++) cycle(1'b0, 77);
        idle_until_quiet();

        // Maximum value.
        cycle(1'b1, 255);
        for (int k = 0; k < 14; k++) cycle(1'b0, 0);
        idle_until_quiet();

        // Back-to-back with start held high.
        cycle(1'b1, 128);
        for (int k = 0; k < 12; k++) cycle(1'b1, (k < 9) ? 200 : 7);
        for (int k = 0; k < 14; k++) cycle(1'b1, (k < 10) ? 33 : 99);
        for (int k = 0; k < 16; k++) cycle(1'b0, 0);
        idle_until_quiet();

        // start pulsed during SHIFT must be ignored.
        p0 = pulses[0];
        p3 = pulses[1];
        cycle(1'b1, 45);
        cycle(1'b0, 45);
        cycle(1'b1, 200);
        cycle(1'b0, 200);
        for (int k = 0; k < 16; k++) cycle(1'b0, 200);
        idle_until_quiet();
        chk("one_pulse1", pulses[0] - p0, 1);
        chk("one_pulse3", pulses[1] - p3, 1);
        chk("ignored_tens", int'(ten[0]), 4);

        // Reset at iteration 4 of 173, then a clean retry.
        cycle(1'b1, 173);
        for (int k = 0; k < 4; k++) cycle(1'b0, 173);
        async_reset();
        cycle(1'b1, 173);
        for (int k = 0; k < 14; k++) cycle(1'b0, 0);
        idle_until_quiet();

        // Value 64 (exercises the long ready hold on the RH=3 instance).
        cycle(1'b1, 64);
        for (int k = 0; k < 14; k++) cycle(1'b0, 0);
        idle_until_quiet();

        // Randomized traffic with occasional asynchronous reset.
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(299) == 0)
                async_reset();
            else
                cycle(($urandom_range(3) == 0), int'($urandom_range(255)));
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
